// File: rtl/rsync_wlevel.sv
// rsync_wlevel: write-domain read-pointer synchronizer and fill-level/status generator.
//
// Brings the Gray-coded read pointer from the rclk domain into wclk and
// converts it to binary. It then compares that pointer with the write
// controller's next binary pointer to produce a registered level, full,
// almost-full and a sticky overflow flag.
//
// Optional build macro:
//   RSYNC_3STAGE_EN  defined   -> 3-flop synchronizer (read path +1 cycle)
//                    undefined -> 2-flop synchronizer
//
// Ports:
//   wclk          in   write clock, rising edge
//   wrst_n        in   asynchronous active-low reset
//   rptr_g        in   read pointer, Gray, from rclk domain (ADDW+1 bits)
//   wbnext        in   next binary write pointer (ADDW+1 bits)
//   wren          in   write request this cycle (overflow detection)
//   wovf_clr      in   synchronous clear of wovf
//   rbin_w        out  synchronized read pointer, binary
//   wlevel        out  registered fill level, 0..DEPTH
//   wfull         out  registered, wlevel == DEPTH
//   walmost_full  out  registered, wlevel >= AF_THRESH
//   wovf          out  sticky, write attempted while full
module rsync_wlevel #(
    parameter int ADDW      = 4,
    parameter int AF_THRESH = 14
) (
    input  logic          wclk,
    input  logic          wrst_n,
    input  logic [ADDW:0] rptr_g,
    input  logic [ADDW:0] wbnext,
    input  logic          wren,
    input  logic          wovf_clr,
    output logic [ADDW:0] rbin_w,
    output logic [ADDW:0] wlevel,
    output logic          wfull,
    output logic          walmost_full,
    output logic          wovf
);
`ifdef RSYNC_3STAGE_EN
    localparam int NSYNC = 3;
`else
    localparam int NSYNC = 2;
`endif
    localparam logic [ADDW:0] DEPTH_P = {1'b1, {ADDW{1'b0}}};
    localparam logic [ADDW:0] AF_P    = AF_THRESH[ADDW:0];

    logic [ADDW:0] sync_q [NSYNC];
    logic [ADDW:0] sync_d [NSYNC];
    logic [ADDW:0] rbin_q, rbin_d;
    logic [ADDW:0] wlevel_q, wlevel_d;
    logic          wfull_q, wfull_d;
    logic          waf_q, waf_d;
    logic          wovf_q, wovf_d;
    logic [ADDW:0] diff;

    always_comb begin
        sync_d[0] = rptr_g;
        for (int i = 1; i < NSYNC; i++) sync_d[i] = sync_q[i-1];
        // Binary bit i is the XOR of all Gray bits at or above i.
        for (int i = 0; i <= ADDW; i++) rbin_d[i] = ^(sync_q[NSYNC-1] >> i);
        // Modulo subtraction keeps the level correct across pointer wrap.
        diff     = wbnext - rbin_q;
        wlevel_d = diff;
        wfull_d  = diff == DEPTH_P;
        waf_d    = diff >= AF_P;
        // Set wins over a simultaneous clear.
        wovf_d   = (wren && wfull_q) ? 1'b1 : wovf_clr ? 1'b0 : wovf_q;
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            for (int i = 0; i < NSYNC; i++) sync_q[i] <= '0;
            rbin_q   <= '0;
            wlevel_q <= '0;
            wfull_q  <= 1'b0;
            waf_q    <= 1'b0;
            wovf_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NSYNC; i++) sync_q[i] <= sync_d[i];
            rbin_q   <= rbin_d;
            wlevel_q <= wlevel_d;
            wfull_q  <= wfull_d;
            waf_q    <= waf_d;
            wovf_q   <= wovf_d;
        end
    end

    assign rbin_w       = rbin_q;
    assign wlevel       = wlevel_q;
    assign wfull        = wfull_q;
    assign walmost_full = waf_q;
    assign wovf         = wovf_q;
endmodule
